// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU operation encoding used by id_stage and the ALU.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the decode stage: I-type (sign-extended), U-type and shift amount.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_u,
  output logic [4:0]  o_shamt
);

  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_u = {i_instr[31:12], 12'b0};
  assign o_shamt = i_instr[24:20];

endmodule

// File: rtl/id_stage.sv
// RV32I integer decode stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands behind a
// single-entry valid/ready pipeline register, counting every handoff to execute.
module id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal,
  output logic [31:0] out_pc,
  output logic [31:0] issue_cnt
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [4:0]  w_shamt;

  alu_op_e     w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_illegal;
  logic        w_wb_en;
  logic        w_accept;
  logic        w_handoff;

  logic        r_valid;
  alu_op_e     r_alu_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_wb_en;
  logic        r_illegal;
  logic [31:0] r_pc;
  logic [31:0] r_issue_cnt;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // x0 is hardwired to zero whatever the register file returns
  assign w_rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign w_rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

  imm_gen u_imm_gen (
    .i_instr (in_instr),
    .o_imm_i (w_imm_i),
    .o_imm_u (w_imm_u),
    .o_shamt (w_shamt)
  );

  always_comb begin
    w_op      = ALU_ADD;
    w_illegal = 1'b1;
    w_a       = 32'd0;
    w_b       = 32'd0;
    unique case (w_opcode)
      OPC_OP: begin
        w_a = w_rs1_val;
        w_b = w_rs2_val;
        unique case (w_funct3)
          F3_ADD: begin
            if (w_funct7 == F7_BASE) begin w_op = ALU_ADD; w_illegal = 1'b0; end
            else if (w_funct7 == F7_ALT) begin w_op = ALU_SUB; w_illegal = 1'b0; end
          end
          F3_SLL:  if (w_funct7 == F7_BASE) begin w_op = ALU_SLL;  w_illegal = 1'b0; end
          F3_SLT:  if (w_funct7 == F7_BASE) begin w_op = ALU_SLT;  w_illegal = 1'b0; end
          F3_SLTU: if (w_funct7 == F7_BASE) begin w_op = ALU_SLTU; w_illegal = 1'b0; end
          F3_XOR:  if (w_funct7 == F7_BASE) begin w_op = ALU_XOR;  w_illegal = 1'b0; end
          F3_SR: begin
            if (w_funct7 == F7_BASE) begin w_op = ALU_SRL; w_illegal = 1'b0; end
            else if (w_funct7 == F7_ALT) begin w_op = ALU_SRA; w_illegal = 1'b0; end
          end
          F3_OR:   if (w_funct7 == F7_BASE) begin w_op = ALU_OR;  w_illegal = 1'b0; end
          F3_AND:  if (w_funct7 == F7_BASE) begin w_op = ALU_AND; w_illegal = 1'b0; end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        w_a = w_rs1_val;
        w_b = w_imm_i;
        unique case (w_funct3)
          F3_ADD:  begin w_op = ALU_ADD;  w_illegal = 1'b0; end
          F3_SLT:  begin w_op = ALU_SLT;  w_illegal = 1'b0; end
          F3_SLTU: begin w_op = ALU_SLTU; w_illegal = 1'b0; end
          F3_XOR:  begin w_op = ALU_XOR;  w_illegal = 1'b0; end
          F3_OR:   begin w_op = ALU_OR;   w_illegal = 1'b0; end
          F3_AND:  begin w_op = ALU_AND;  w_illegal = 1'b0; end
          F3_SLL: begin
            w_b = {27'd0, w_shamt};
            if (w_funct7 == F7_BASE) begin w_op = ALU_SLL; w_illegal = 1'b0; end
          end
          F3_SR: begin
            w_b = {27'd0, w_shamt};
            if (w_funct7 == F7_BASE) begin w_op = ALU_SRL; w_illegal = 1'b0; end
            else if (w_funct7 == F7_ALT) begin w_op = ALU_SRA; w_illegal = 1'b0; end
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        w_b       = w_imm_u;
        w_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        w_a       = in_pc;
        w_b       = w_imm_u;
        w_illegal = 1'b0;
      end
      default: ;
    endcase
    // an illegal instruction travels as a harmless ADD 0,0 with no write-back
    if (w_illegal) begin
      w_op = ALU_ADD;
      w_a  = 32'd0;
      w_b  = 32'd0;
    end
  end

  assign w_wb_en   = !w_illegal && (w_rd != 5'd0);
  assign in_ready  = !rst_n || !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_issue_cnt <= 32'd0;
      r_alu_op    <= ALU_ADD;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_rd        <= 5'd0;
      r_wb_en     <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= 32'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      if (w_handoff) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_alu_op  <= w_op;
        r_a       <= w_a;
        r_b       <= w_b;
        r_rd      <= w_rd;
        r_wb_en   <= w_wb_en;
        r_illegal <= w_illegal;
        r_pc      <= in_pc;
      end else if (w_handoff) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_alu_op  = r_alu_op;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign out_rd      = r_rd;
  assign out_wb_en   = r_wb_en;
  assign out_illegal = r_illegal;
  assign out_pc      = r_pc;
  assign issue_cnt   = r_issue_cnt;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode vectors, backpressure, flush, reset and illegal stream.
module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;
  logic [31:0] out_pc;
  logic [31:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_illegal (out_illegal),
    .out_pc      (out_pc),
    .issue_cnt   (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wb,
                         input logic ill);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".op"}, {28'd0, out_alu_op}, {28'd0, op});
    chk({tag, ".a"}, out_a, a);
    chk({tag, ".b"}, out_b, b);
    chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, ".wb"}, {31'd0, out_wb_en}, {31'd0, wb});
    chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33);
    in_pc = 32'h0; rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    tick();
    // reset state, acceptance ignored during reset
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.cnt", issue_cnt, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.op", {28'd0, out_alu_op}, 32'd0);
    chk("rst.a", out_a, 32'd0);
    chk("rst.pc", out_pc, 32'd0);

    // ADD x3,x1,x2
    rst_n = 1'b1; out_ready = 1'b1; in_pc = 32'h40;
    #1;
    chk("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
    tick();
    chk_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    chk("add.pc", out_pc, 32'h40);
    chk("add.cnt", issue_cnt, 32'd0);

    // ADDI x1,x0,-1 (rs1_data must be ignored for x0)
    in_instr = {12'hFFF, 5'd0, 3'b000, 5'd1, 7'h13}; rs1_data = 32'h55;
    tick();
    chk_out("addi", 4'd0, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    chk("addi.cnt", issue_cnt, 32'd1);

    // SRAI x2,x2,4
    in_instr = enc_r(7'h20, 5'd4, 5'd2, 3'b101, 5'd2, 7'h13); rs1_data = 32'h80;
    tick();
    chk_out("srai", 4'd7, 32'h80, 32'd4, 5'd2, 1'b1, 1'b0);
    chk("srai.cnt", issue_cnt, 32'd2);

    // AUIPC x5,0x12345 at pc 0x100
    in_instr = {20'h12345, 5'd5, 7'h17}; in_pc = 32'h100;
    tick();
    chk_out("auipc", 4'd0, 32'h100, 32'h1234_5000, 5'd5, 1'b1, 1'b0);
    chk("auipc.cnt", issue_cnt, 32'd3);

    // backpressure: SUB x4,x1,x2 waits behind held AUIPC
    in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33); in_pc = 32'h104;
    rs1_data = 32'd10; rs2_data = 32'd3; out_ready = 1'b0;
    #1;
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 4'd0, 32'h100, 32'h1234_5000, 5'd5, 1'b1, 1'b0);
      chk("stall.cnt", issue_cnt, 32'd3);
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("sub", 4'd1, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0);
    chk("sub.pc", out_pc, 32'h104);
    chk("sub.cnt", issue_cnt, 32'd4);

    // flush with held SUB and a new instruction offered in the same cycle
    flush = 1'b1;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd7, 7'h33);
    tick();
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.cnt", issue_cnt, 32'd4);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush2.valid", {31'd0, out_valid}, 32'd0);
    chk("flush2.cnt", issue_cnt, 32'd4);

    // reset mid-handshake discards a held instruction
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("hold.valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst2.valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.cnt", issue_cnt, 32'd0);
    chk("rst2.rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;

    // back-to-back stream of 4: opcode 0x7F, bad funct7, LUI, ADD to x0
    in_instr = 32'h0000_02FF;
    tick();
    chk_out("ill7f", 4'd0, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1);
    chk("ill7f.cnt", issue_cnt, 32'd0);
    in_instr = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33);
    tick();
    chk_out("illf7", 4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
    chk("illf7.cnt", issue_cnt, 32'd1);
    in_instr = {20'hABCDE, 5'd6, 7'h37};
    tick();
    chk_out("lui", 4'd0, 32'd0, 32'hABCD_E000, 5'd6, 1'b1, 1'b0);
    chk("lui.cnt", issue_cnt, 32'd2);
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33);
    rs1_data = 32'd1; rs2_data = 32'd2;
    tick();
    chk_out("addx0", 4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
    chk("addx0.cnt", issue_cnt, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
    chk("drain.cnt", issue_cnt, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
